// File: rtl/transport_packetizer.sv
// Frames control words and audio samples into fixed-size typed, channel-tagged,
// sequence-numbered byte packets, queues whole packets and streams one per request.
module transport_packetizer #(
  parameter int PACKET_BYTES = 16,
  parameter int SAMPLE_BYTES = 2,
  parameter int NUM_CHANNELS = 4,
  parameter int READY_PKTS   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    cmd,
  input  logic [1:0]                    chan,
  input  logic [8*SAMPLE_BYTES-1:0]     data,
  input  logic                          send_data,
  output logic                          sending,
  output logic [7:0]                    packet_out,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(READY_PKTS):0]   pkt_count
);

  localparam int N_SAMPLES  = (PACKET_BYTES - 1) / SAMPLE_BYTES;
  localparam int FIFO_BYTES = READY_PKTS * PACKET_BYTES;
  localparam int CTRL_BYTES = (SAMPLE_BYTES < PACKET_BYTES) ? SAMPLE_BYTES : PACKET_BYTES - 1;
  localparam int SW         = 8 * SAMPLE_BYTES;
  localparam int PTR_W      = $clog2(FIFO_BYTES);
  localparam int CNT_W      = $clog2(FIFO_BYTES + 1);
  localparam int IDX_W      = $clog2(PACKET_BYTES);
  localparam int ACNT_W     = $clog2(N_SAMPLES + 1);
  localparam int PC_W       = $clog2(READY_PKTS) + 1;

  localparam logic [PTR_W-1:0]  LAST_PTR     = PTR_W'(FIFO_BYTES - 1);
  localparam logic [CNT_W-1:0]  FIFO_BYTES_L = CNT_W'(FIFO_BYTES);
  localparam logic [CNT_W-1:0]  PKT_BYTES_L  = CNT_W'(PACKET_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(PACKET_BYTES - 1);
  localparam logic [ACNT_W-1:0] LAST_SMP     = ACNT_W'(N_SAMPLES - 1);
  localparam logic [2:0]        NUM_CH_L     = 3'(NUM_CHANNELS);

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_CTRL  = 2'b01,
    CMD_AUDIO = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  typedef enum logic {WR_IDLE = 1'b0, WR_BUSY = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Assembly buffer and packet writer state
  logic [SW-1:0]      asm_q [N_SAMPLES];
  logic [SW-1:0]      asm_d [N_SAMPLES];
  logic [SW-1:0]      asm_ins [N_SAMPLES];
  logic [SW-1:0]      aud_src [N_SAMPLES];
  logic [ACNT_W-1:0]  asm_cnt_q, asm_cnt_d, aud_cnt;
  logic [1:0]         asm_chan_q, asm_chan_d, aud_chan, chan_eff;
  logic [3:0]         ctrl_seq_q, ctrl_seq_d, audio_seq_q, audio_seq_d;
  logic [7:0]         ctrl_pkt [PACKET_BYTES];
  logic [7:0]         aud_pkt [PACKET_BYTES];
  logic [7:0]         wr_pkt_q [PACKET_BYTES];
  logic [7:0]         wr_pkt_d [PACKET_BYTES];
  wr_state_e          wr_state_q, wr_state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               req, accept, emit_ctrl, emit_audio;

  // Ready FIFO and reader state
  logic [7:0]         fifo_mem_q [FIFO_BYTES];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic               fifo_we, fifo_re, pkt_inc, pkt_dec;
  rd_state_e          rd_state_q, rd_state_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;

  logic               sending_q, sending_d;
  logic [7:0]         packet_out_q, packet_out_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [PC_W-1:0]    pkt_count_q, pkt_count_d;

  // Request acceptance and audio assembly; decides which packet the writer loads
  always_comb begin
    chan_eff   = ({1'b0, chan} < NUM_CH_L) ? chan : 2'b00;
    req        = (cmd != CMD_IDLE);
    accept     = req && !busy_q;
    overflow_d = req && busy_q;
    for (int k = 0; k < N_SAMPLES; k++) begin
      asm_ins[k] = (ACNT_W'(k) == asm_cnt_q) ? data : asm_q[k];
    end
    asm_d      = asm_q;
    asm_cnt_d  = asm_cnt_q;
    asm_chan_d = asm_chan_q;
    aud_src    = asm_q;
    aud_cnt    = asm_cnt_q;
    aud_chan   = asm_chan_q;
    emit_ctrl  = 1'b0;
    emit_audio = 1'b0;
    if (accept) begin
      case (cmd)
        CMD_CTRL: emit_ctrl = 1'b1;
        CMD_AUDIO: begin
          if ((asm_cnt_q != '0) && (chan_eff != asm_chan_q)) begin
            // channel change: ship the partial packet, this sample opens the next one
            emit_audio = 1'b1;
            asm_d[0]   = data;
            asm_cnt_d  = ACNT_W'(1);
            asm_chan_d = chan_eff;
          end else if (asm_cnt_q == LAST_SMP) begin
            emit_audio = 1'b1;
            aud_src    = asm_ins;
            aud_cnt    = ACNT_W'(N_SAMPLES);
            aud_chan   = chan_eff;
            asm_cnt_d  = '0;
          end else begin
            asm_d      = asm_ins;
            asm_cnt_d  = asm_cnt_q + ACNT_W'(1);
            asm_chan_d = chan_eff;
          end
        end
        CMD_FLUSH: begin
          if (asm_cnt_q != '0) begin
            emit_audio = 1'b1;
            asm_cnt_d  = '0;
          end else begin
            emit_audio = 1'b0;
          end
        end
        default: emit_ctrl = 1'b0;
      endcase
    end else begin
      emit_ctrl = 1'b0;
    end
  end

  // Byte images of the candidate control and audio packets
  always_comb begin
    for (int i = 0; i < PACKET_BYTES; i++) begin
      ctrl_pkt[i] = 8'h00;
      aud_pkt[i]  = 8'hFF;
    end
    ctrl_pkt[0] = {2'b01, chan_eff, ctrl_seq_q};
    aud_pkt[0]  = {2'b10, aud_chan, audio_seq_q};
    for (int j = 0; j < CTRL_BYTES; j++) begin
      ctrl_pkt[1 + j] = data[8*(SAMPLE_BYTES-1-j) +: 8];
    end
    for (int k = 0; k < N_SAMPLES; k++) begin
      for (int j = 0; j < SAMPLE_BYTES; j++) begin
        aud_pkt[1 + k*SAMPLE_BYTES + j] =
          (ACNT_W'(k) < aud_cnt) ? aud_src[k][8*(SAMPLE_BYTES-1-j) +: 8] : 8'hFF;
      end
    end
  end

  // Writer FSM: latches a packet image, then commits one byte per cycle
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_pkt_d    = wr_pkt_q;
    ctrl_seq_d  = ctrl_seq_q;
    audio_seq_d = audio_seq_q;
    fifo_we     = 1'b0;
    pkt_inc     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        wr_idx_d = '0;
        if (emit_ctrl) begin
          wr_pkt_d   = ctrl_pkt;
          wr_state_d = WR_BUSY;
          ctrl_seq_d = ctrl_seq_q + 4'd1;
        end else if (emit_audio) begin
          wr_pkt_d    = aud_pkt;
          wr_state_d  = WR_BUSY;
          audio_seq_d = audio_seq_q + 4'd1;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_BUSY: begin
        fifo_we = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          wr_state_d = WR_IDLE;
          pkt_inc    = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Reader FSM: streams one whole packet; the idle state forces a gap cycle
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_idx_d     = rd_idx_q;
    rd_ptr_d     = rd_ptr_q;
    sending_d    = 1'b0;
    packet_out_d = 8'h00;
    fifo_re      = 1'b0;
    pkt_dec      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (send_data && (pkt_count_q != '0)) begin
          rd_state_d   = RD_SEND;
          rd_idx_d     = '0;
          fifo_re      = 1'b1;
          pkt_dec      = 1'b1;
          sending_d    = 1'b1;
          packet_out_d = fifo_mem_q[rd_ptr_q];
          rd_ptr_d     = ptr_inc(rd_ptr_q);
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_SEND: begin
        if (rd_idx_q == LAST_IDX) begin
          rd_state_d = RD_IDLE;
        end else begin
          fifo_re      = 1'b1;
          sending_d    = 1'b1;
          packet_out_d = fifo_mem_q[rd_ptr_q];
          rd_ptr_d     = ptr_inc(rd_ptr_q);
          rd_idx_d     = rd_idx_q + IDX_W'(1);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // FIFO occupancy, packet count and flow-control status
  always_comb begin
    wr_ptr_d    = fifo_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(fifo_we) - CNT_W'(fifo_re);
    pkt_count_d = pkt_count_q + PC_W'(pkt_inc) - PC_W'(pkt_dec);
    busy_d      = (wr_state_d == WR_BUSY) || ((FIFO_BYTES_L - fifo_cnt_d) < PKT_BYTES_L);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q        <= '{default: '0};
      asm_cnt_q    <= '0;
      asm_chan_q   <= 2'b00;
      ctrl_seq_q   <= 4'd0;
      audio_seq_q  <= 4'd0;
      wr_pkt_q     <= '{default: 8'h00};
      wr_state_q   <= WR_IDLE;
      wr_idx_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      rd_state_q   <= RD_IDLE;
      rd_idx_q     <= '0;
      sending_q    <= 1'b0;
      packet_out_q <= 8'h00;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      asm_q        <= asm_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_chan_q   <= asm_chan_d;
      ctrl_seq_q   <= ctrl_seq_d;
      audio_seq_q  <= audio_seq_d;
      wr_pkt_q     <= wr_pkt_d;
      wr_state_q   <= wr_state_d;
      wr_idx_q     <= wr_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      rd_state_q   <= rd_state_d;
      rd_idx_q     <= rd_idx_d;
      sending_q    <= sending_d;
      packet_out_q <= packet_out_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  // Ready FIFO storage; emptiness is tracked by the reset pointers and count
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_mem_q[wr_ptr_q] <= wr_pkt_q[wr_idx_q];
    end
  end

  assign sending    = sending_q;
  assign packet_out = packet_out_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_transport_packetizer.sv
// Directed bench for transport_packetizer at its default parameters (16-byte packets,
// 2-byte samples, 4 channels, 4-packet ready FIFO).
module tb_transport_packetizer;

  localparam int PB = 16;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [1:0]  cmd       = 2'b00;
  logic [1:0]  chan      = 2'b00;
  logic [15:0] data      = 16'h0000;
  logic        send_data = 1'b0;
  logic        sending;
  logic [7:0]  packet_out;
  logic        busy;
  logic        overflow;
  logic [2:0]  pkt_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_pkt [PB];
  logic [15:0] smp [8];

  transport_packetizer #(
    .PACKET_BYTES(16),
    .SAMPLE_BYTES(2),
    .NUM_CHANNELS(4),
    .READY_PKTS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd(cmd),
    .chan(chan),
    .data(data),
    .send_data(send_data),
    .sending(sending),
    .packet_out(packet_out),
    .busy(busy),
    .overflow(overflow),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd       = 2'b00;
    send_data = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [1:0] ch, input logic [15:0] d);
    cmd  = c;
    chan = ch;
    data = d;
    tick(1);
    cmd = 2'b00;
  endtask

  task automatic set_ctrl_exp(input logic [7:0] hdr, input logic [15:0] d);
    for (int i = 0; i < PB; i++) exp_pkt[i] = 8'h00;
    exp_pkt[0] = hdr;
    exp_pkt[1] = d[15:8];
    exp_pkt[2] = d[7:0];
  endtask

  task automatic set_aud_exp(input logic [7:0] hdr, input int n);
    for (int i = 0; i < PB; i++) exp_pkt[i] = 8'hFF;
    exp_pkt[0] = hdr;
    for (int k = 0; k < n; k++) begin
      exp_pkt[1 + 2*k] = smp[k][15:8];
      exp_pkt[2 + 2*k] = smp[k][7:0];
    end
  endtask

  // Requests one packet and compares all its bytes plus the trailing idle cycle.
  task automatic read_packet(input string tag, input bit hold);
    send_data = 1'b1;
    tick(1);
    if (!hold) send_data = 1'b0;
    check_val({tag, "_sending"}, 32'(sending), 32'd1);
    for (int i = 0; i < PB; i++) begin
      if (i > 0) tick(1);
      check_val($sformatf("%s_b%0d", tag, i), 32'(packet_out), 32'(exp_pkt[i]));
    end
    tick(1);
    check_val({tag, "_gap"}, 32'(sending), 32'd0);
  endtask

  initial begin
    // 1: reset values and a single control packet
    do_reset();
    check_val("rst_sending", 32'(sending), 32'd0);
    check_val("rst_pkt_out", 32'(packet_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_pkt_count", 32'(pkt_count), 32'd0);
    issue(2'b01, 2'd2, 16'hABCD);
    check_val("t1_busy_wr", 32'(busy), 32'd1);
    tick(15);
    check_val("t1_cnt_pre", 32'(pkt_count), 32'd0);
    tick(1);
    check_val("t1_cnt_post", 32'(pkt_count), 32'd1);
    check_val("t1_busy_done", 32'(busy), 32'd0);
    set_ctrl_exp(8'h60, 16'hABCD);
    read_packet("t1", 1'b0);
    check_val("t1_cnt_end", 32'(pkt_count), 32'd0);

    // 2: two full audio packets on chan 1, read back-to-back with send_data held
    do_reset();
    for (int k = 0; k < 7; k++) issue(2'b10, 2'd1, 16'(k + 1));
    tick(17);
    for (int k = 0; k < 7; k++) issue(2'b10, 2'd1, 16'(k + 8));
    tick(17);
    check_val("t2_cnt", 32'(pkt_count), 32'd2);
    for (int k = 0; k < 7; k++) smp[k] = 16'(k + 1);
    set_aud_exp(8'h90, 7);
    read_packet("t2a", 1'b1);
    for (int k = 0; k < 7; k++) smp[k] = 16'(k + 8);
    set_aud_exp(8'h91, 7);
    read_packet("t2b", 1'b0);

    // 3: flush of a partial packet, empty flush, channel switch
    do_reset();
    smp[0] = 16'h1111; smp[1] = 16'h2222; smp[2] = 16'h3333;
    for (int k = 0; k < 3; k++) issue(2'b10, 2'd0, smp[k]);
    check_val("t3_busy_aud", 32'(busy), 32'd0);
    issue(2'b11, 2'd0, 16'h0000);
    tick(17);
    set_aud_exp(8'h80, 3);
    read_packet("t3a", 1'b0);
    issue(2'b11, 2'd0, 16'h0000);
    tick(3);
    check_val("t3_empty_cnt", 32'(pkt_count), 32'd0);
    check_val("t3_empty_ovf", 32'(overflow), 32'd0);
    issue(2'b10, 2'd0, 16'hA0A0);
    issue(2'b10, 2'd3, 16'hB0B0);
    tick(17);
    issue(2'b11, 2'd0, 16'h0000);
    tick(17);
    check_val("t3_sw_cnt", 32'(pkt_count), 32'd2);
    smp[0] = 16'hA0A0;
    set_aud_exp(8'h81, 1);
    read_packet("t3b", 1'b0);
    smp[0] = 16'hB0B0;
    set_aud_exp(8'hB2, 1);
    read_packet("t3c", 1'b0);

    // 4: ready FIFO full, rejected request, space recovered by one read
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(2'b01, 2'd0, 16'(k));
      tick(17);
    end
    check_val("t4_cnt_full", 32'(pkt_count), 32'd4);
    check_val("t4_busy_full", 32'(busy), 32'd1);
    issue(2'b01, 2'd1, 16'h5A5A);
    check_val("t4_ovf_pulse", 32'(overflow), 32'd1);
    check_val("t4_cnt_keep", 32'(pkt_count), 32'd4);
    tick(1);
    check_val("t4_ovf_clear", 32'(overflow), 32'd0);
    set_ctrl_exp(8'h40, 16'h0000);
    read_packet("t4", 1'b0);
    check_val("t4_busy_free", 32'(busy), 32'd0);
    check_val("t4_cnt_after", 32'(pkt_count), 32'd3);

    // 5: control request in the middle of audio assembly
    do_reset();
    smp[0] = 16'h0101; smp[1] = 16'h0202; smp[2] = 16'h0303;
    for (int k = 0; k < 3; k++) issue(2'b10, 2'd2, smp[k]);
    issue(2'b01, 2'd1, 16'hBEEF);
    tick(17);
    for (int k = 3; k < 7; k++) begin
      smp[k] = {8'(k + 1), 8'(k + 1)};
      issue(2'b10, 2'd2, smp[k]);
    end
    tick(17);
    check_val("t5_cnt", 32'(pkt_count), 32'd2);
    set_ctrl_exp(8'h50, 16'hBEEF);
    read_packet("t5c", 1'b0);
    set_aud_exp(8'hA0, 7);
    read_packet("t5a", 1'b0);
    issue(2'b01, 2'd1, 16'h0000);
    tick(17);
    set_ctrl_exp(8'h51, 16'h0000);
    read_packet("t5d", 1'b0);

    // 6: reset while a packet is being sent
    do_reset();
    issue(2'b01, 2'd3, 16'h1234);
    tick(17);
    issue(2'b01, 2'd0, 16'h9999);
    tick(17);
    send_data = 1'b1;
    tick(1);
    send_data = 1'b0;
    check_val("t6_hdr", 32'(packet_out), 32'h70);
    tick(5);
    check_val("t6_b5", 32'(packet_out), 32'h00);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("t6_rst_sending", 32'(sending), 32'd0);
    check_val("t6_rst_cnt", 32'(pkt_count), 32'd0);
    check_val("t6_rst_pkt_out", 32'(packet_out), 32'd0);
    tick(2);
    check_val("t6_no_resume", 32'(sending), 32'd0);
    issue(2'b01, 2'd0, 16'h5555);
    tick(17);
    check_val("t6_cnt", 32'(pkt_count), 32'd1);
    set_ctrl_exp(8'h40, 16'h5555);
    read_packet("t6", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
